// File: rtl/uart_pixel_rx.sv
// rtl/uart_pixel_rx.sv - mid-bit majority-vote UART receiver that packs characters into pixels
// Optional parity bit after the data bits is enabled by defining UART_PARITY_EN.
module uart_pixel_rx #(
  parameter int CLK_FREQ         = 50_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int DATA_BITS        = 8,
  parameter int BYTES_PER_PIXEL  = 1,
  parameter int PIXELS_PER_FRAME = 16384,
  parameter int GAP_TIMEOUT_BITS = 20,
  parameter int PARITY_ODD       = 0
) (
  input  logic                                 sys_clk,
  input  logic                                 sys_rst,
  input  logic                                 rx,
  output logic [DATA_BITS-1:0]                 byte_data,
  output logic                                 byte_vld,
  output logic                                 frame_err,
  output logic                                 parity_err,
  output logic [BYTES_PER_PIXEL*DATA_BITS-1:0] pix_data,
  output logic                                 pix_vld,
  output logic [$clog2(PIXELS_PER_FRAME)-1:0]  pix_cnt,
  output logic                                 frame_done
);
  localparam int BIT_CNT = CLK_FREQ / BAUD_RATE;
  localparam int CW      = $clog2(BIT_CNT + 1);
  localparam int PW      = BYTES_PER_PIXEL * DATA_BITS;
  localparam int PCW     = $clog2(PIXELS_PER_FRAME);
  localparam int BW      = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam int GAP_CYC = GAP_TIMEOUT_BITS * BIT_CNT;
  localparam int GW      = $clog2(GAP_CYC + 1);

  localparam logic [CW-1:0]  SAMP_A  = CW'(BIT_CNT / 2 - 1);
  localparam logic [CW-1:0]  SAMP_B  = CW'(BIT_CNT / 2);
  localparam logic [CW-1:0]  SAMP_C  = CW'(BIT_CNT / 2 + 1);
  localparam logic [CW-1:0]  BC_M1   = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [2:0]     DB_M1   = 3'(DATA_BITS - 1);
  localparam logic [BW-1:0]  BPP_M1  = BW'(BYTES_PER_PIXEL - 1);
  localparam logic [PCW-1:0] PPF_M1  = PCW'(PIXELS_PER_FRAME - 1);
  localparam logic [GW-1:0]  GAP_M1  = GW'(GAP_CYC - 1);

  if (BIT_CNT < 8) begin : g_chk_bit_cnt
    $error("uart_pixel_rx: CLK_FREQ/BAUD_RATE must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_data_bits
    $error("uart_pixel_rx: DATA_BITS must be 5..8");
  end
  if (BYTES_PER_PIXEL < 1 || BYTES_PER_PIXEL > 4) begin : g_chk_bpp
    $error("uart_pixel_rx: BYTES_PER_PIXEL must be 1..4");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_chk_parity
    $error("uart_pixel_rx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_meta_d;
  logic                   rx_sync_q, rx_sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic                   s0_q, s0_d;
  logic                   s1_q, s1_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [BW-1:0]          byte_idx_q, byte_idx_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [PCW-1:0]         pix_idx_q, pix_idx_d;
  logic [DATA_BITS-1:0]   byte_data_q, byte_data_d;
  logic                   byte_vld_q, byte_vld_d;
  logic                   frame_err_q, frame_err_d;
  logic [PW-1:0]          pix_data_q, pix_data_d;
  logic                   pix_vld_q, pix_vld_d;
  logic [PCW-1:0]         pix_cnt_q, pix_cnt_d;
  logic                   frame_done_q, frame_done_d;
  logic                   maj, vote_now, bit_end, good_char, par_bad;
  logic [PW-1:0]          pix_shift;

  // Third sample is taken live; the first two were latched on the preceding cycles.
  assign maj      = (s0_q & s1_q) | (s0_q & rx_sync_q) | (s1_q & rx_sync_q);
  assign vote_now = (cnt_q == SAMP_C);
  assign bit_end  = (cnt_q == BC_M1);

  if (BYTES_PER_PIXEL == 1) begin : g_pix1
    assign pix_shift = shift_q;
  end else begin : g_pixn
    assign pix_shift = {pix_data_q[PW-DATA_BITS-1:0], shift_q};
  end

`ifdef UART_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;
  assign par_bad    = par_bad_q;
  assign parity_err = parity_err_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_comb begin
    rx_meta_d    = rx;
    rx_sync_d    = rx_meta_q;
    state_d      = state_q;
    cnt_d        = bit_end ? '0 : cnt_q + 1'b1;
    bit_idx_d    = bit_idx_q;
    s0_d         = (cnt_q == SAMP_A) ? rx_sync_q : s0_q;
    s1_d         = (cnt_q == SAMP_B) ? rx_sync_q : s1_q;
    shift_d      = shift_q;
    byte_idx_d   = byte_idx_q;
    gap_d        = '0;
    pix_idx_d    = pix_idx_q;
    byte_data_d  = byte_data_q;
    byte_vld_d   = 1'b0;
    frame_err_d  = 1'b0;
    pix_data_d   = pix_data_q;
    pix_vld_d    = 1'b0;
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = 1'b0;
    good_char    = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // The detecting sample is sample 0 of the start bit.
        cnt_d = rx_sync_q ? '0 : CNT_ONE;
        if (!rx_sync_q) state_d = START;
      end
      START: begin
        if (vote_now && maj) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (vote_now) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bit_idx_q == DB_M1) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (vote_now) par_bad_d = (^shift_q) ^ maj ^ (PARITY_ODD != 0);
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (vote_now) begin
          if (maj) begin
            byte_vld_d  = 1'b1;
            byte_data_d = shift_q;
            good_char   = ~par_bad;
            state_d     = IDLE;
`ifdef UART_PARITY_EN
            parity_err_d = par_bad_q;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
            cnt_d       = '0;
          end
        end
      end
      WAIT_HIGH: begin
        if (!rx_sync_q) begin
          cnt_d = '0;
        end else if (cnt_q == BC_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A partial pixel left idle too long is dropped so the next pixel starts aligned.
    if (state_q == IDLE && byte_idx_q != '0) begin
      if (gap_q == GAP_M1) byte_idx_d = '0;
      else                 gap_d      = gap_q + 1'b1;
    end

    if (good_char) begin
      pix_data_d = pix_shift;
      if (byte_idx_q == BPP_M1) begin
        pix_vld_d    = 1'b1;
        pix_cnt_d    = pix_idx_q;
        frame_done_d = (pix_idx_q == PPF_M1);
        pix_idx_d    = (pix_idx_q == PPF_M1) ? '0 : pix_idx_q + 1'b1;
        byte_idx_d   = '0;
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      s0_q         <= 1'b1;
      s1_q         <= 1'b1;
      shift_q      <= '0;
      byte_idx_q   <= '0;
      gap_q        <= '0;
      pix_idx_q    <= '0;
      byte_data_q  <= '0;
      byte_vld_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_vld_q    <= 1'b0;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      shift_q      <= shift_d;
      byte_idx_q   <= byte_idx_d;
      gap_q        <= gap_d;
      pix_idx_q    <= pix_idx_d;
      byte_data_q  <= byte_data_d;
      byte_vld_q   <= byte_vld_d;
      frame_err_q  <= frame_err_d;
      pix_data_q   <= pix_data_d;
      pix_vld_q    <= pix_vld_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
`ifdef UART_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_vld   = byte_vld_q;
  assign frame_err  = frame_err_q;
  assign pix_data   = pix_data_q;
  assign pix_vld    = pix_vld_q;
  assign pix_cnt    = pix_cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/uart_pixel_rx.md
Name: uart_pixel_rx

Overview:
Parametrised UART receiver for the serial image-load path: oversample-free mid-bit receiver with 3-point majority voting, framing check and optional parity. It packs received bytes into pixels (1–4 bytes each) and counts pixels per frame. It sits between the board rx pin and the frame-buffer write port of the dehazing pipeline. It replaces the fixed 8N1/RGB332 receiver and supports RGB565/RGB888 loads without RTL edits.

Parameters:
CLK_FREQ, 50_000_000, sys_clk frequency in Hz
BAUD_RATE, 9600, line rate; BIT_CNT = CLK_FREQ/BAUD_RATE (integer division, must be >= 8)
DATA_BITS, 8, data bits per character, 5..8
BYTES_PER_PIXEL, 1, characters per pixel, 1..4; first received = most significant
PIXELS_PER_FRAME, 16384, pixels per frame before the counter wraps
GAP_TIMEOUT_BITS, 20, idle bit-times inside a partial pixel before it is discarded
PARITY_ODD, 0, 0 = even, 1 = odd; used only with UART_PARITY_EN

Ports:
sys_clk  in  1  clock
sys_rst  in  1  synchronous reset, active-high
rx  in  1  asynchronous serial input, idle high
byte_data  out  DATA_BITS  last good character
byte_vld  out  1  one-cycle strobe, byte_data valid
frame_err  out  1  one-cycle strobe, stop bit sampled low
parity_err  out  1  one-cycle strobe, parity mismatch (tied 0 without UART_PARITY_EN)
pix_data  out  BYTES_PER_PIXEL*DATA_BITS  assembled pixel
pix_vld  out  1  one-cycle strobe, pix_data valid
pix_cnt  out  clog2(PIXELS_PER_FRAME)  index of pixel presented with pix_vld
frame_done  out  1  one-cycle strobe coincident with pix_vld of the last pixel in the frame

Behaviour:
- Clocking and reset: one clock, sys_clk. Reset is synchronous and active-high on sys_rst.
- Reset values: all outputs 0; FSM in IDLE; synchroniser flops 1; byte and pixel counters 0.
- Input synchronisation: rx passes through a 2-flop synchroniser before use; all timing below refers to the synchronised rx.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP, WAIT_HIGH.
- IDLE -> START on the first synchronised-low sample. The bit counter restarts at 0.
- Sampling: each bit is sampled at BIT_CNT/2-1, BIT_CNT/2 and BIT_CNT/2+1 within the bit; the bit value is the majority of the 3 samples.
- START: if the majority is 1, it is a false start and the FSM returns to IDLE with no strobe. Otherwise the FSM enters DATA at the end of the bit.
- DATA: captures DATA_BITS bits LSB first, then goes to PARITY or STOP.
- STOP, majority 1: byte_vld pulses the cycle after the voting sample. byte_data updates in the same cycle and holds until the next good character. The FSM then returns to IDLE without waiting for the end of the stop bit, which tolerates a fast transmitter.
- STOP, majority 0: frame_err pulses and the character is dropped. The FSM enters WAIT_HIGH, which returns to IDLE after 1 full bit-time of continuous high.
- A character with a parity error still pulses byte_vld, but it is not packed into a pixel.
- Pixel packing:
  - Each good character shifts into the pixel register.
  - When the byte counter reaches BYTES_PER_PIXEL-1, pix_vld pulses in the same cycle as byte_vld, pix_cnt shows the current index, and the byte counter clears.
  - When BYTES_PER_PIXEL = 1, pix_vld equals byte_vld.
- Frame counting: pix_cnt increments after each pix_vld. When it equals PIXELS_PER_FRAME-1, frame_done pulses with that pix_vld and pix_cnt wraps to 0 on the next pixel.
- Gap timeout: while the byte counter is non-zero and the FSM is in IDLE, a counter runs. After GAP_TIMEOUT_BITS*BIT_CNT cycles the partial pixel is discarded (byte counter cleared); pix_cnt is unchanged. The counter clears on any start bit.
- frame_err does not clear a partial pixel; only the gap timeout or reset does.
- Reset mid-character: reset has priority; no strobe is emitted.
- Strobe width: every strobe is exactly one cycle wide.

Optional Feature:
UART_PARITY_EN
- Defined: the PARITY state samples one parity bit after the data bits. A mismatch against even/odd parity (per PARITY_ODD) pulses parity_err in the byte_vld cycle, and that character is excluded from packing.
- Undefined: there is no PARITY state, parity_err is constant 0, and the frame format is 1 start, DATA_BITS data, 1 stop.

Test Plan:
- Bench parameters: CLK_FREQ=160, BAUD_RATE=10 (BIT_CNT=16), 8 data bits, 1 byte per pixel, PIXELS_PER_FRAME=4. Send 0xA5 -> byte_vld and pix_vld once, byte_data=0xA5, pix_cnt=0, no errors.
- Same settings, send 0x11, 0x22, 0x33, 0x44, 0x55 -> frame_done on the 0x44 pix_vld (pix_cnt=3); 0x55 gives pix_cnt=0.
- BYTES_PER_PIXEL=2: send 0xF8, 0x1F -> one pix_vld with pix_data=0xF81F. Then send 0xAB, wait 21 bit-times, send 0xCD, 0xEF -> pix_data=0xCDEF; 0xAB is discarded.
- Glitch and framing: a low pulse of 4 cycles on rx -> no strobes, FSM back in IDLE. Send 0x3C with the stop bit forced low -> frame_err pulse, no byte_vld; with rx then high for 16 cycles, the next 0x3C is received normally.
- Majority vote: send 0x81 with a 1-cycle inversion at one of the 3 sample points of bit 0 -> byte_data=0x81.
- With UART_PARITY_EN and PARITY_ODD=0: send 0x07 with parity bit 1 -> byte_vld and no parity_err. Send 0x07 with parity bit 0 -> parity_err pulse and no pix_vld.
